// File: rtl/req_arbiter8.sv
// Eight-way request arbiter: fixed-priority or round-robin winner selection,
// bounded grant hold time, and a mandatory release/idle gap between grants.
module req_arbiter8 #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       mode,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid,
   output logic       timeout,
   output logic       any_req
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t     state, state_nx;
   logic [2:0] ptr, ptr_nx;
   logic [2:0] owner, owner_nx;
   logic [7:0] hold_cnt, hold_nx;
   logic [7:0] grant_nx;
   logic [2:0] id_nx;
   logic       valid_nx;
   logic       timeout_nx;
   logic [2:0] win;
   logic       drop;
   logic       expire;

   function automatic logic [2:0] fixed_pick(input logic [7:0] r);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (r[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Search starts at the pointer and wraps; the first hit wins.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic [2:0] cand;
      logic       found;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cand = p + 3'(k);
         if (!found && r[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   assign any_req = |req;
   assign win     = mode ? rr_pick(req, ptr) : fixed_pick(req);
   assign drop    = !req[owner] || !ena;
   assign expire  = (hold_cnt == 8'(HOLD_MAX));

   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      owner_nx   = owner;
      hold_nx    = hold_cnt;
      grant_nx   = 8'd0;
      id_nx      = 3'd0;
      valid_nx   = 1'b0;
      timeout_nx = 1'b0;
      case (state)
         IDLE: begin
            hold_nx = 8'd0;
            if (ena && any_req) begin
               state_nx = GRANT;
               owner_nx = win;
               grant_nx = 8'b1 << win;
               id_nx    = win;
               valid_nx = 1'b1;
               hold_nx  = 8'd1;
            end
         end
         GRANT: begin
            if (drop || expire) begin
               // A dropped request or disable masks the expiry pulse.
               state_nx   = RELEASE;
               timeout_nx = expire && !drop;
               hold_nx    = 8'd0;
            end else begin
               grant_nx = grant;
               id_nx    = owner;
               valid_nx = 1'b1;
               hold_nx  = hold_cnt + 8'd1;
            end
         end
         RELEASE: begin
            state_nx = IDLE;
            ptr_nx   = owner + 3'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd0;
         owner       <= 3'd0;
         hold_cnt    <= 8'd0;
         grant       <= 8'd0;
         grant_id    <= 3'd0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         owner       <= owner_nx;
         hold_cnt    <= hold_nx;
         grant       <= grant_nx;
         grant_id    <= id_nx;
         grant_valid <= valid_nx;
         timeout     <= timeout_nx;
      end
   end

endmodule

// File: doc/req_arbiter8.md
REQ_ARBITER8 -- requirements
Module: req_arbiter8

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum consecutive grant cycles per win, legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  arbitration enable; low blocks new grants and ends any active grant.
REQ-005 mode  input  1  0 = fixed priority (index 7 highest), 1 = round-robin.
REQ-006 req  input  8  request vector; bit i = requester i.
REQ-007 grant  output  8  one-hot grant vector; all-zero when no grant.
REQ-008 grant_id  output  3  binary index of the granted requester; 0 when no grant.
REQ-009 grant_valid  output  1  high exactly when grant is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is ended by hold expiry.
REQ-011 any_req  output  1  combinational: 1 when req != 0 (independent of ena and state).

Function
REQ-012 FSM states IDLE, GRANT, RELEASE; all outputs except any_req are registered.
REQ-013 IDLE: ena=1 and req!=0 -> winner latched, GRANT next cycle; otherwise stay IDLE; grant=0.
REQ-014 Latency: request sampled in cycle N appears on grant/grant_id/grant_valid in cycle N+1.
REQ-015 Fixed mode winner: highest set index of req (req=8'b0010_0110 -> 5).
REQ-016 Round-robin winner: first set index found searching ptr, ptr+1, ... 7, 0, ... ptr-1 (mod-8 wrap).
REQ-017 mode sampled only at the IDLE decision edge; changes during GRANT/RELEASE have no effect on the current grant.
REQ-018 GRANT: hold_cnt = 1 in first grant cycle, +1 each further grant cycle; 8-bit counter, no wrap needed within legal HOLD_MAX.
REQ-019 GRANT exit to RELEASE when any of: req[grant_id]=0, ena=0, or hold_cnt==HOLD_MAX; evaluated every cycle.
REQ-020 Expiry: with req held, grant lasts exactly HOLD_MAX cycles.
REQ-021 Simultaneous exit causes: req drop or ena=0 take precedence; timeout not asserted.
REQ-022 RELEASE: lasts exactly one cycle; grant=0, grant_valid=0, grant_id=0; timeout=1 only if exit cause was expiry alone.
REQ-023 RELEASE: ptr <= grant_id+1 mod 8 (7 -> 0) in both modes; next state IDLE.
REQ-024 No back-to-back grants: at least one RELEASE and one IDLE cycle between grants (minimum 2 idle cycles on grant).
REQ-025 Requests rising in any state other than IDLE are ignored until the IDLE decision edge; no request queuing.
REQ-026 grant always one-hot or zero; grant_valid == (grant != 0); grant[grant_id]==1 whenever grant_valid.

Reset
REQ-027 rst_n=0 at a rising edge: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_id=0, grant_valid=0, timeout=0.
REQ-028 Reset mid-GRANT or mid-RELEASE aborts immediately; no timeout pulse; no ptr update beyond reset value.
REQ-029 First arbitration after reset release occurs at the first edge with rst_n=1.

Verification
REQ-030 Fixed: mode=0, ena=1, req=8'b1000_0001 held -> cycle+1 grant=8'h80, grant_id=7; held 15 cycles, timeout pulse, 1 IDLE cycle, then grant=8'h80 again.
REQ-031 Round-robin wrap: mode=1, req=8'hFF held, HOLD_MAX=2 -> grant_id sequence 0,1,...,7,0; each grant 2 cycles, gap 2 cycles, timeout every RELEASE.
REQ-032 Release: grant to 3 active, req[3] dropped in grant cycle 4 -> next cycle grant=0, timeout=0; ptr=4 (mode=1 next winner with req=8'h09 is 3 after 0? -> search from 4: winner 0).
REQ-033 Enable: ena=0 with req=8'h10 -> no grant, any_req=1; ena drop mid-grant -> RELEASE next cycle, timeout=0.
REQ-034 Simultaneous: req drop in the same cycle hold_cnt==HOLD_MAX -> RELEASE, timeout=0.
REQ-035 Reset: rst_n=0 during GRANT (grant=8'h04) -> next edge all outputs 0, ptr=0; rst_n=1 with req=8'h0C, mode=1 -> grant_id=2.
